// File: rtl/uart_rx_fsm_if.sv
// Control bundle between the UART RX frame controller (master) and the RX datapath (slave).
// Line/sampler/config inputs flow to the controller; one-cycle strobes and status flow back.
interface uart_rx_fsm_if #(
  parameter int PRESC_W = 6
);
  logic               rx_in;
  logic               sampled_bit;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_err;
  logic [PRESC_W-1:0] edge_cnt;
  logic               sample_en;
  logic               deser_en;
  logic               par_load;
  logic               par_chk_en;
  logic               strt_glitch;
  logic               stp_err;
  logic               data_valid;
  logic               busy;

  modport master (
    input  rx_in, sampled_bit, prescale, par_en, par_err,
    output edge_cnt, sample_en, deser_en, par_load, par_chk_en,
           strt_glitch, stp_err, data_valid, busy
  );

  modport slave (
    output rx_in, sampled_bit, prescale, par_en, par_err,
    input  edge_cnt, sample_en, deser_en, par_load, par_chk_en,
           strt_glitch, stp_err, data_valid, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: start / data / parity / stop sequencing with oversample and bit counters.
// Strobes land in the cycle edge_cnt hits their sample point; no backpressure, the line sets the pace.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fsm_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int                BW       = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]     BIT_ONE  = BW'(1);
  localparam logic [PRESC_W-1:0] P_MIN   = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] ONE     = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] TWO     = PRESC_W'(2);

  logic [2:0]         state, state_nx;
  logic [PRESC_W-1:0] edge_cnt, edge_nx;
  logic [PRESC_W-1:0] p_lat, p_eff, half, h1, h2;
  logic [BW-1:0]      bit_cnt, bit_nx;
  logic               pen_lat, perr_flag, at_last;
  logic               start_mid, stop_mid, deser_q, par_load_q, par_chk_q;

  assign p_eff   = (bus.prescale[0] || (bus.prescale < P_MIN)) ? P_MIN : bus.prescale;
  assign half    = p_lat >> 1;
  assign h1      = half + ONE;
  assign h2      = half + TWO;
  assign at_last = (edge_cnt == (p_lat - ONE));

  always_comb begin
    state_nx = state;
    edge_nx  = edge_cnt + ONE;
    bit_nx   = bit_cnt;
    case (state)
      IDLE: begin
        edge_nx = '0;
        if (!bus.rx_in) state_nx = START;
      end
      START: begin
        if ((edge_cnt == h1) && bus.sampled_bit) begin
          state_nx = IDLE;
          edge_nx  = '0;
        end else if (at_last) begin
          state_nx = DATA;
          edge_nx  = '0;
          bit_nx   = '0;
        end
      end
      DATA: begin
        if (at_last) begin
          edge_nx = '0;
          bit_nx  = bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) state_nx = pen_lat ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_last) begin
          state_nx = STOP;
          edge_nx  = '0;
        end
      end
      STOP: begin
        // Leave right after the stop sample so a back-to-back start bit is not missed.
        if (edge_cnt == h1) begin
          state_nx = IDLE;
          edge_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        edge_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= '0;
      pen_lat    <= 1'b0;
      perr_flag  <= 1'b0;
      start_mid  <= 1'b0;
      stop_mid   <= 1'b0;
      deser_q    <= 1'b0;
      par_load_q <= 1'b0;
      par_chk_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      edge_cnt <= edge_nx;
      bit_cnt  <= bit_nx;
      if ((state == IDLE) && (state_nx == START)) begin
        p_lat     <= p_eff;
        pen_lat   <= bus.par_en;
        perr_flag <= 1'b0;
      end else if ((state == PARITY) && (edge_cnt == h2)) begin
        perr_flag <= bus.par_err & pen_lat;
      end
      // Look ahead one cycle so each strobe is a flop output aligned to its edge_cnt slot.
      start_mid  <= (state_nx == START)  && (edge_nx == h1);
      stop_mid   <= (state_nx == STOP)   && (edge_nx == h1);
      deser_q    <= (state_nx == DATA)   && (edge_nx == h1);
      par_load_q <= (state_nx == PARITY) && (edge_nx == h1);
      par_chk_q  <= (state_nx == PARITY) && (edge_nx >= h2);
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.sample_en   = (state != IDLE);
  assign bus.deser_en    = deser_q;
  assign bus.par_load    = par_load_q;
  assign bus.par_chk_en  = par_chk_q;
  assign bus.strt_glitch = start_mid & bus.sampled_bit;
  assign bus.stp_err     = stop_mid & ~bus.sampled_bit;
  assign bus.data_valid  = stop_mid & bus.sampled_bit & ~(perr_flag & pen_lat);
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives serial frames, records per-frame strobe activity, compares to hand values.
module tb_uart_rx_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_err = 1'b0;
  logic [5:0] presc = 6'd8;

  always #5 clk = ~clk;

  uart_rx_fsm_if #(.PRESC_W(6)) bus ();
  assign bus.rx_in       = rx_in;
  assign bus.sampled_bit = rx_in;
  assign bus.prescale    = presc;
  assign bus.par_en      = par_en;
  assign bus.par_err     = par_err;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int n_des; int t_des0; int last_des; int gap; logic [7:0] dat;
    int n_pl; int t_pl; int n_pce; int n_dv; int t_dv; int n_se; int n_sg; int t_sg;
    int max_edge; int len; int pre_idle;
  } rec_t;

  rec_t cur;
  rec_t hist [0:31];
  int   cyc = 0, t0 = 0, mt = 0, nfr = 0, idle_strb = 0, last_fall = 0;
  int   checks = 0, errors = 0;
  bit   prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-frame recorder: a frame spans from busy rising to busy falling.
  always @(negedge clk) begin
    if (bus.busy && !prev_busy) begin
      cur = '{default: 0};
      cur.pre_idle = cyc - last_fall;
      t0 = cyc;
    end
    mt = cyc - t0;
    if (bus.busy) begin
      if (int'(bus.edge_cnt) > cur.max_edge) cur.max_edge = int'(bus.edge_cnt);
      if (bus.deser_en) begin
        if (cur.n_des == 0) cur.t_des0 = mt;
        else if (cur.n_des == 1) cur.gap = mt - cur.last_des;
        else if (mt - cur.last_des != cur.gap) cur.gap = -1;
        cur.last_des = mt;
        cur.n_des += 1;
        cur.dat = {bus.sampled_bit, cur.dat[7:1]};
      end
      if (bus.par_load) begin cur.n_pl += 1; cur.t_pl = mt; end
      if (bus.par_chk_en) cur.n_pce += 1;
      if (bus.data_valid) begin cur.n_dv += 1; cur.t_dv = mt; end
      if (bus.stp_err) cur.n_se += 1;
      if (bus.strt_glitch) begin cur.n_sg += 1; cur.t_sg = mt; end
    end else if (prev_busy) begin
      cur.len = mt;
      if (nfr < 32) hist[nfr] = cur;
      nfr += 1;
      last_fall = cyc;
    end
    if (!bus.busy && (bus.deser_en || bus.par_load || bus.par_chk_en ||
                      bus.strt_glitch || bus.stp_err || bus.data_valid))
      idle_strb += 1;
    prev_busy = bus.busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks += 1;
    if (obs !== exp) begin
      errors += 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (nfr < n && k < 2000) begin
      @(posedge clk);
      k += 1;
    end
    chk("frame_done", int'(nfr >= n), 1);
  endtask

  // Serial frame aligned to the IDLE-exit edge; the stop bit is held only up to its sample point + 1.
  task automatic send_frame(input int p, input logic [7:0] d, input bit pen, input bit stp,
                            input int glen, input int abort_t, input int chg_t);
    logic [10:0] bits;
    int nb, total;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pen) begin bits[9] = ^d; bits[10] = stp; nb = 11; end
    else begin bits[9] = stp; nb = 10; end
    total = (glen > 0) ? (p / 2 + 2) : ((nb - 1) * p + p / 2 + 2);
    par_en = pen;
    @(negedge clk);
    rx_in = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < total; t++) begin
      if (glen > 0) rx_in = (t < glen) ? 1'b0 : 1'b1;
      else rx_in = bits[t / p];
      if (t == chg_t) begin presc = 6'd8; par_en = ~pen; end
      if (t == abort_t) reset = 1'b0;
      @(posedge clk); #1;
      if (t == abort_t) begin reset = 1'b1; break; end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_edge", int'(bus.edge_cnt), 0);
    chk("rst_sample_en", int'(bus.sample_en), 0);
    chk("rst_dv", int'(bus.data_valid), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // F0: P=8, no parity, 0x55
    send_frame(8, 8'h55, 1'b0, 1'b1, 0, -1, -1);
    wait_frames(1);
    chk("f0_n_des", hist[0].n_des, 8);
    chk("f0_t_des0", hist[0].t_des0, 13);
    chk("f0_gap", hist[0].gap, 8);
    chk("f0_dat", int'(hist[0].dat), 'h55);
    chk("f0_n_dv", hist[0].n_dv, 1);
    chk("f0_t_dv", hist[0].t_dv, 77);
    chk("f0_err", hist[0].n_se + hist[0].n_sg + hist[0].n_pl, 0);
    chk("f0_max_edge", hist[0].max_edge, 7);
    chk("f0_len", hist[0].len, 78);

    // F1..F3: parity frames, good / bad / good
    par_err = 1'b0;
    send_frame(8, 8'hA3, 1'b1, 1'b1, 0, -1, -1);
    par_err = 1'b1;
    send_frame(8, 8'hA3, 1'b1, 1'b1, 0, -1, -1);
    par_err = 1'b0;
    send_frame(8, 8'hA3, 1'b1, 1'b1, 0, -1, -1);
    wait_frames(4);
    chk("f1_n_pl", hist[1].n_pl, 1);
    chk("f1_t_pl", hist[1].t_pl, 77);
    chk("f1_n_pce", hist[1].n_pce, 2);
    chk("f1_n_dv", hist[1].n_dv, 1);
    chk("f1_t_dv", hist[1].t_dv, 85);
    chk("f1_dat", int'(hist[1].dat), 'hA3);
    chk("f1_len", hist[1].len, 86);
    chk("f2_n_pl", hist[2].n_pl, 1);
    chk("f2_n_dv", hist[2].n_dv, 0);
    chk("f2_n_se", hist[2].n_se, 0);
    chk("f3_n_dv", hist[3].n_dv, 1);

    // F4: start glitch, line back high after 3 clks
    send_frame(8, 8'h00, 1'b0, 1'b1, 3, -1, -1);
    wait_frames(5);
    chk("f4_n_sg", hist[4].n_sg, 1);
    chk("f4_t_sg", hist[4].t_sg, 5);
    chk("f4_n_des", hist[4].n_des, 0);
    chk("f4_len", hist[4].len, 6);
    chk("f4_n_dv", hist[4].n_dv, 0);

    // F5: stop bit low, then F6 back-to-back
    send_frame(8, 8'h5A, 1'b0, 1'b0, 0, -1, -1);
    send_frame(8, 8'h3C, 1'b0, 1'b1, 0, -1, -1);
    wait_frames(7);
    chk("f5_n_se", hist[5].n_se, 1);
    chk("f5_n_dv", hist[5].n_dv, 0);
    chk("f5_len", hist[5].len, 78);
    chk("f6_pre_idle", hist[6].pre_idle, 1);
    chk("f6_n_dv", hist[6].n_dv, 1);
    chk("f6_t_dv", hist[6].t_dv, 77);
    chk("f6_dat", int'(hist[6].dat), 'h3C);

    // F7: reset while bit_cnt==4, then F8 decodes normally
    send_frame(8, 8'hFF, 1'b0, 1'b1, 0, 43, -1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_edge", int'(bus.edge_cnt), 0);
    chk("abort_strobes", int'({bus.deser_en, bus.par_load, bus.par_chk_en, bus.data_valid,
                                bus.stp_err, bus.strt_glitch, bus.sample_en}), 0);
    send_frame(8, 8'h96, 1'b0, 1'b1, 0, -1, -1);
    wait_frames(9);
    chk("f7_n_des", hist[7].n_des, 4);
    chk("f7_n_dv", hist[7].n_dv, 0);
    chk("f8_n_dv", hist[8].n_dv, 1);
    chk("f8_dat", int'(hist[8].dat), 'h96);

    // F9: P=16 with prescale/par_en disturbed mid-frame; F10: P=32; F11: prescale=5 acts as 8
    presc = 6'd16;
    send_frame(16, 8'hC6, 1'b0, 1'b1, 0, -1, 20);
    presc = 6'd32;
    send_frame(32, 8'h0F, 1'b0, 1'b1, 0, -1, -1);
    presc = 6'd5;
    send_frame(8, 8'hE1, 1'b0, 1'b1, 0, -1, -1);
    wait_frames(12);
    chk("f9_t_des0", hist[9].t_des0, 25);
    chk("f9_gap", hist[9].gap, 16);
    chk("f9_max_edge", hist[9].max_edge, 15);
    chk("f9_t_dv", hist[9].t_dv, 153);
    chk("f9_n_pl", hist[9].n_pl, 0);
    chk("f9_dat", int'(hist[9].dat), 'hC6);
    chk("f10_t_des0", hist[10].t_des0, 49);
    chk("f10_gap", hist[10].gap, 32);
    chk("f10_max_edge", hist[10].max_edge, 31);
    chk("f10_t_dv", hist[10].t_dv, 305);
    chk("f10_dat", int'(hist[10].dat), 'h0F);
    chk("f11_t_des0", hist[11].t_des0, 13);
    chk("f11_max_edge", hist[11].max_edge, 7);
    chk("f11_n_dv", hist[11].n_dv, 1);
    chk("f11_dat", int'(hist[11].dat), 'hE1);

    chk("idle_strobes", idle_strb, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
